// File: rtl/via_bus_if.sv
// 6502-side bus bundle between the chip-select decoder/CPU and the VIA-lite responder.
interface via_bus_if;
  logic       phi2;
  logic       cs;
  logic       rwb;
  logic [2:0] rs;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;
  logic       irq_n;

  modport master (
    output phi2, cs, rwb, rs, d_in,
    input  d_out, d_oe, irq_n
  );

  modport slave (
    input  phi2, cs, rwb, rs, d_in,
    output d_out, d_oe, irq_n
  );
endinterface

// File: rtl/via_lite_responder.sv
// VIA-style peripheral behind the 6502 decode: two GPIO ports with direction
// registers and a 16-bit down-counting T1 timer with a maskable active-low IRQ.
module via_lite_responder #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter bit          T1_CONTINUOUS = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  via_bus_if.slave     bus,
  input  logic [7:0]   pa_in,
  output logic [7:0]   pa_out,
  output logic [7:0]   pa_oe,
  input  logic [7:0]   pb_in,
  output logic [7:0]   pb_out,
  output logic [7:0]   pb_oe
);

  localparam int unsigned SW   = 30;
  localparam int unsigned LAST = SYNC_STAGES - 1;
  localparam int unsigned PREV = SYNC_STAGES - 2;

  localparam logic [2:0] RS_ORB  = 3'd0;
  localparam logic [2:0] RS_ORA  = 3'd1;
  localparam logic [2:0] RS_DDRB = 3'd2;
  localparam logic [2:0] RS_DDRA = 3'd3;
  localparam logic [2:0] RS_T1L  = 3'd4;
  localparam logic [2:0] RS_T1H  = 3'd5;
  localparam logic [2:0] RS_IFR  = 3'd6;
  localparam logic [2:0] RS_IER  = 3'd7;

  // All bus and pin inputs share one synchroniser chain so they stay aligned.
  logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
  logic [SW-1:0]                  sync_in;

  assign sync_in = {bus.phi2, bus.cs, bus.rwb, bus.rs, bus.d_in, pa_in, pb_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= sync_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  logic       phi2_s;
  logic       phi2_p;
  logic       cs_s;
  logic       rwb_s;
  logic [2:0] rs_s;
  logic [7:0] d_in_s;
  logic [7:0] pa_s;
  logic [7:0] pb_s;

  assign {phi2_s, cs_s, rwb_s, rs_s, d_in_s, pa_s, pb_s} = sync_q[LAST];
  assign phi2_p = sync_q[PREV][SW-1];

  logic fall_c;
  logic wr_c;
  logic rd_c;

  assign fall_c = phi2_s & ~phi2_p;
  assign wr_c   = fall_c & cs_s & ~rwb_s;
  assign rd_c   = fall_c & cs_s & rwb_s;

  // Architectural state
  logic [7:0]  ora_q,  ora_d;
  logic [7:0]  orb_q,  orb_d;
  logic [7:0]  ddra_q, ddra_d;
  logic [7:0]  ddrb_q, ddrb_d;
  logic [15:0] t1_latch_q, t1_latch_d;
  logic [15:0] t1_cnt_q,   t1_cnt_d;
  logic        t1_armed_q, t1_armed_d;
  logic        ifr6_q, ifr6_d;
  logic        ier6_q, ier6_d;
  logic [7:0]  d_out_q;
  logic        d_oe_q;
  logic        irq_n_q;

  logic        t1h_wr_c;
  logic        ifr_clr_c;
  logic [7:0]  rd_data_c;

  assign t1h_wr_c  = wr_c & (rs_s == RS_T1H);
  assign ifr_clr_c = (rd_c & (rs_s == RS_T1L)) |
                     (wr_c & (rs_s == RS_IFR) & d_in_s[6]);

  // Read mux; input bits come from the synchronised pins where direction is input.
  always_comb begin
    rd_data_c = 8'h00;
    case (rs_s)
      RS_ORB:  rd_data_c = (orb_q & ddrb_q) | (pb_s & ~ddrb_q);
      RS_ORA:  rd_data_c = (ora_q & ddra_q) | (pa_s & ~ddra_q);
      RS_DDRB: rd_data_c = ddrb_q;
      RS_DDRA: rd_data_c = ddra_q;
      RS_T1L:  rd_data_c = t1_cnt_q[7:0];
      RS_T1H:  rd_data_c = t1_cnt_q[15:8];
      RS_IFR:  rd_data_c = {ifr6_q & ier6_q, ifr6_q, 6'b0};
      RS_IER:  rd_data_c = {1'b1, ier6_q, 6'b0};
      default: rd_data_c = 8'h00;
    endcase
  end

  // Register writes and the T1 step, both committed on the phi2 fall.
  always_comb begin
    ora_d      = ora_q;
    orb_d      = orb_q;
    ddra_d     = ddra_q;
    ddrb_d     = ddrb_q;
    t1_latch_d = t1_latch_q;
    t1_cnt_d   = t1_cnt_q;
    t1_armed_d = t1_armed_q;
    ifr6_d     = ifr6_q;
    ier6_d     = ier6_q;

    if (wr_c) begin
      case (rs_s)
        RS_ORB:  orb_d  = d_in_s;
        RS_ORA:  ora_d  = d_in_s;
        RS_DDRB: ddrb_d = d_in_s;
        RS_DDRA: ddra_d = d_in_s;
        RS_T1L:  t1_latch_d[7:0]  = d_in_s;
        RS_T1H:  t1_latch_d[15:8] = d_in_s;
        RS_IER:  if (d_in_s[6]) ier6_d = d_in_s[7];
        default: ;
      endcase
    end

    if (fall_c) begin
      if (ifr_clr_c) begin
        ifr6_d = 1'b0;
      end
      // Load takes precedence over expiry; expiry set takes precedence over clear.
      if (t1h_wr_c) begin
        t1_cnt_d   = {d_in_s, t1_latch_q[7:0]};
        t1_armed_d = 1'b1;
        ifr6_d     = 1'b0;
      end else if (t1_cnt_q != 16'h0000) begin
        t1_cnt_d = 16'(t1_cnt_q - 16'd1);
      end else if (t1_armed_q) begin
        ifr6_d = 1'b1;
        if (T1_CONTINUOUS) begin
          t1_cnt_d = t1_latch_q;
        end else begin
          t1_cnt_d   = 16'hFFFF;
          t1_armed_d = 1'b0;
        end
      end else begin
        t1_cnt_d = 16'hFFFF;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ora_q      <= 8'h00;
      orb_q      <= 8'h00;
      ddra_q     <= 8'h00;
      ddrb_q     <= 8'h00;
      t1_latch_q <= 16'h0000;
      t1_cnt_q   <= 16'h0000;
      t1_armed_q <= 1'b0;
      ifr6_q     <= 1'b0;
      ier6_q     <= 1'b0;
      d_out_q    <= 8'h00;
      d_oe_q     <= 1'b0;
      irq_n_q    <= 1'b1;
    end else begin
      ora_q      <= ora_d;
      orb_q      <= orb_d;
      ddra_q     <= ddra_d;
      ddrb_q     <= ddrb_d;
      t1_latch_q <= t1_latch_d;
      t1_cnt_q   <= t1_cnt_d;
      t1_armed_q <= t1_armed_d;
      ifr6_q     <= ifr6_d;
      ier6_q     <= ier6_d;
      d_out_q    <= rd_data_c;
      d_oe_q     <= cs_s & rwb_s & phi2_s;
      irq_n_q    <= ~(ifr6_q & ier6_q);
    end
  end

  assign bus.d_out = d_out_q;
  assign bus.d_oe  = d_oe_q;
  assign bus.irq_n = irq_n_q;

  assign pa_out = ora_q;
  assign pa_oe  = ddra_q;
  assign pb_out = orb_q;
  assign pb_oe  = ddrb_q;

endmodule

// File: tb/tb_via_lite_responder.sv
// Directed bench: one-shot and free-running T1 instances driven by the same bus stimulus.
module tb_via_lite_responder;

  logic       clk;
  logic       rst;
  logic       phi2;
  logic       cs;
  logic       rwb;
  logic [2:0] rs;
  logic [7:0] d_in;
  logic [7:0] pa_in;
  logic [7:0] pb_in;

  logic [7:0] pa_out0, pa_oe0, pb_out0, pb_oe0;
  logic [7:0] pa_out1, pa_oe1, pb_out1, pb_oe1;

  int total;
  int bad;

  logic [7:0] r0;
  logic [7:0] r1;
  logic       oe_seen;

  via_bus_if bi0 ();
  via_bus_if bi1 ();

  assign bi0.phi2 = phi2;
  assign bi0.cs   = cs;
  assign bi0.rwb  = rwb;
  assign bi0.rs   = rs;
  assign bi0.d_in = d_in;
  assign bi1.phi2 = phi2;
  assign bi1.cs   = cs;
  assign bi1.rwb  = rwb;
  assign bi1.rs   = rs;
  assign bi1.d_in = d_in;

  via_lite_responder #(.SYNC_STAGES(2), .T1_CONTINUOUS(1'b0)) u_dut0 (
    .clk    (clk),
    .rst    (rst),
    .bus    (bi0.slave),
    .pa_in  (pa_in),
    .pa_out (pa_out0),
    .pa_oe  (pa_oe0),
    .pb_in  (pb_in),
    .pb_out (pb_out0),
    .pb_oe  (pb_oe0)
  );

  via_lite_responder #(.SYNC_STAGES(2), .T1_CONTINUOUS(1'b1)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .bus    (bi1.slave),
    .pa_in  (pa_in),
    .pa_out (pa_out1),
    .pa_oe  (pa_oe1),
    .pb_in  (pb_in),
    .pb_out (pb_out1),
    .pb_oe  (pb_oe1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  // One full phi2 cycle; read data is captured just before the falling edge.
  task automatic bus_cycle(input logic c, input logic r, input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    cs = c; rwb = r; rs = a; d_in = d;
    oe_seen = 1'b0;
    repeat (2) @(negedge clk);
    phi2 = 1'b1;
    repeat (8) begin
      @(negedge clk);
      oe_seen = oe_seen | bi0.d_oe | bi1.d_oe;
    end
    r0 = bi0.d_out;
    r1 = bi1.d_out;
    phi2 = 1'b0;
    repeat (8) begin
      @(negedge clk);
      oe_seen = oe_seen | bi0.d_oe | bi1.d_oe;
    end
    cs = 1'b0; rwb = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus_cycle(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [2:0] a);
    bus_cycle(1'b1, 1'b1, a, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b1, 3'd0, 8'h00);
  endtask

  // Select a register with phi2 held low and let the registered read path settle.
  task automatic peek(input logic [2:0] a);
    @(negedge clk);
    rs = a;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; phi2 = 1'b0; cs = 1'b0; rwb = 1'b1; rs = 3'd0; d_in = 8'h00;
    pa_in = 8'h00; pb_in = 8'h00;
    r0 = 8'h00; r1 = 8'h00; oe_seen = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Reset state
    check("rst_d_oe",  {7'b0, bi0.d_oe}, 8'h00);
    check("rst_irq_n", {7'b0, bi0.irq_n}, 8'h01);
    check("rst_pa_oe", pa_oe0, 8'h00);
    check("rst_pb_oe", pb_oe0, 8'h00);
    check("rst_pa_out", pa_out0, 8'h00);
    check("rst_pb_out", pb_out0, 8'h00);
    for (int a = 0; a < 8; a++) begin
      peek(3'(a));
      check($sformatf("rst_read_rs%0d", a), bi0.d_out, (a == 7) ? 8'h80 : 8'h00);
    end
    check("rst_d_oe_idle", {7'b0, bi0.d_oe}, 8'h00);

    // Port A direction/output and mixed read-back
    wr(3'd3, 8'hF0);
    wr(3'd1, 8'hA5);
    check("pa_oe", pa_oe0, 8'hF0);
    check("pa_out", pa_out0, 8'hA5);
    pa_in = 8'h3C;
    rd(3'd1);
    check("ora_read", r0, 8'hAC);
    check("ora_read_d_oe", {7'b0, oe_seen}, 8'h01);
    rd(3'd3);
    check("ddra_read", r0, 8'hF0);

    // One-shot T1 with load of 3: flag on the 4th following fall, no re-fire
    wr(3'd7, 8'hC0);
    wr(3'd4, 8'h03);
    wr(3'd5, 8'h00);
    idle(3);
    check("t1_os_before", {7'b0, bi0.irq_n}, 8'h01);
    idle(1);
    check("t1_os_fire", {7'b0, bi0.irq_n}, 8'h00);
    idle(2);
    check("t1_os_hold", {7'b0, bi0.irq_n}, 8'h00);
    rd(3'd4);
    check("t1_os_cnt_lo", r0, 8'hFD);
    check("t1_os_clear", {7'b0, bi0.irq_n}, 8'h01);
    idle(4);
    check("t1_os_no_refire", {7'b0, bi0.irq_n}, 8'h01);

    // Free-running T1 with latch 0002: flag every 3 falls
    wr(3'd7, 8'hC0);
    wr(3'd4, 8'h02);
    wr(3'd5, 8'h00);
    idle(2);
    check("t1_fr_before", {7'b0, bi1.irq_n}, 8'h01);
    idle(1);
    check("t1_fr_fire1", {7'b0, bi1.irq_n}, 8'h00);
    rd(3'd6);
    check("t1_fr_ifr_read", r1, 8'hC0);
    wr(3'd6, 8'h40);
    check("t1_fr_clr1", {7'b0, bi1.irq_n}, 8'h01);
    idle(1);
    check("t1_fr_fire2", {7'b0, bi1.irq_n}, 8'h00);
    wr(3'd6, 8'h40);
    check("t1_fr_clr2", {7'b0, bi1.irq_n}, 8'h01);
    idle(1);
    check("t1_fr_gap", {7'b0, bi1.irq_n}, 8'h01);
    idle(1);
    check("t1_fr_fire3", {7'b0, bi1.irq_n}, 8'h00);
    wr(3'd6, 8'h40);
    check("t1_fr_clr3", {7'b0, bi1.irq_n}, 8'h01);
    idle(1);
    wr(3'd6, 8'h40);
    check("t1_fr_set_wins", {7'b0, bi1.irq_n}, 8'h00);
    idle(2);
    wr(3'd5, 8'h00);
    check("t1_fr_load_wins", {7'b0, bi1.irq_n}, 8'h01);

    // Deselected accesses are ignored and never drive the bus
    bus_cycle(1'b0, 1'b0, 3'd2, 8'hFF);
    check("nocs_pb_oe", pb_oe0, 8'h00);
    check("nocs_wr_d_oe", {7'b0, oe_seen}, 8'h00);
    bus_cycle(1'b0, 1'b1, 3'd3, 8'h00);
    check("nocs_rd_d_oe", {7'b0, oe_seen}, 8'h00);

    // Reset in the middle of a T1 count
    wr(3'd4, 8'h10);
    wr(3'd5, 8'h00);
    idle(5);
    check("pre_rst_irq_n", {7'b0, bi0.irq_n}, 8'h01);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_irq_n", {7'b0, bi0.irq_n}, 8'h01);
    check("mid_rst_pa_oe", pa_oe0, 8'h00);
    peek(3'd4);
    check("mid_rst_cnt_lo", bi0.d_out, 8'h00);
    peek(3'd5);
    check("mid_rst_cnt_hi", bi0.d_out, 8'h00);
    wr(3'd7, 8'hC0);
    idle(40);
    check("post_rst_irq_n", {7'b0, bi0.irq_n}, 8'h01);
    peek(3'd6);
    check("post_rst_ifr", bi0.d_out, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
